// File: rtl/uart_fifo_ext.sv
// Synchronous first-word-fall-through FIFO for the UART RX and TX paths.
// It provides a fill level, almost-full and almost-empty thresholds, sticky overflow
// and underflow flags, and a synchronous flush. When the FIFO is full, OvfMode selects
// whether an incoming word is dropped (0) or overwrites the oldest word (1).
module uart_fifo_ext #(
  parameter int DataWidth   = 8,
  parameter int Depth       = 128,
  parameter int AFullLevel  = 96,
  parameter int AEmptyLevel = 8,
  parameter int OvfMode     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       err_clr,
  input  logic                       wr_en,
  input  logic [DataWidth-1:0]       wr_data,
  input  logic                       rd_en,
  output logic [DataWidth-1:0]       rd_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(Depth):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0]   LvlDepth = (AW+1)'(Depth);
  localparam logic [AW:0]   LvlAFull = (AW+1)'(AFullLevel);
  localparam logic [AW:0]   LvlAEmpt = (AW+1)'(AEmptyLevel);
  localparam logic [AW:0]   LvlOne   = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic pop_ok, pop_bad, push_ok, push_full, ovr_wr, do_write;

  assign empty        = (level_q == '0);
  assign full         = (level_q == LvlDepth);
  assign almost_empty = (level_q <= LvlAEmpt);
  assign almost_full  = (level_q >= LvlAFull);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign rd_data      = empty ? '0 : mem_q[rd_ptr_q];

  // Classify this cycle's requests and compute the next pointer, level and flag state.
  always_comb begin
    pop_ok    = rd_en && !empty;
    pop_bad   = rd_en && empty;
    // A valid pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    push_ok   = wr_en && (!full || pop_ok);
    push_full = wr_en && full && !pop_ok;
    ovr_wr    = push_full && (OvfMode == 1);
    do_write  = !clr && (push_ok || ovr_wr);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + PtrOne;
      // In overwrite mode the oldest word is discarded, so the read pointer moves past it.
      if (pop_ok || ovr_wr) rd_ptr_d = rd_ptr_q + PtrOne;
      if (push_ok && !pop_ok) level_d = level_q + LvlOne;
      else if (pop_ok && !push_ok) level_d = level_q - LvlOne;
    end

    // Setting a flag takes priority over clearing it in the same cycle.
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (!clr && push_full) ovf_d = 1'b1;
    if (!clr && pop_bad)   udf_d = 1'b1;
  end

  // Update the pointers, the level and the sticky flags. Reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array. It has no reset because the level masks any stale contents.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_fifo_ext.sv
// Bench for uart_fifo_ext. It runs a drop-mode and an overwrite-mode instance side by
// side, with both instances driven by the same inputs. A queue model checks every
// output on every falling edge. Hand-computed checks pin the model's key values.
module tb_uart_fifo_ext;

  logic clk = 1'b0;
  logic rst_n, clr, err_clr, wr_en, rd_en;
  logic [7:0] wr_data;

  logic [7:0] rd_data0, rd_data1;
  logic [7:0] level0, level1;
  logic empty0, full0, ae0, af0, ovf0, udf0;
  logic empty1, full1, ae1, af1, ovf1, udf1;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  always #5 clk = ~clk;

  uart_fifo_ext #(.DataWidth(8), .Depth(128), .AFullLevel(96), .AEmptyLevel(8), .OvfMode(0)) u_drop (
    .clk(clk), .rst_n(rst_n), .clr(clr), .err_clr(err_clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data0),
    .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
    .level(level0), .overflow(ovf0), .underflow(udf0));

  uart_fifo_ext #(.DataWidth(8), .Depth(128), .AFullLevel(96), .AEmptyLevel(8), .OvfMode(1)) u_ovw (
    .clk(clk), .rst_n(rst_n), .clr(clr), .err_clr(err_clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data1),
    .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
    .level(level1), .overflow(ovf1), .underflow(udf1));

  // ---------------- model ----------------
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  bit movf[2];
  bit mudf[2];

  function automatic int msize(int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic int mhead(int k);
    if (msize(k) == 0) return 0;
    return (k == 0) ? int'(mq0[0]) : int'(mq1[0]);
  endfunction

  task automatic mpush(int k, logic [7:0] d);
    if (k == 0) mq0.push_back(d); else mq1.push_back(d);
  endtask

  task automatic mpop(int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  task automatic mstep(int k);
    int sz;
    bit popv, oset, uset;
    sz = msize(k);
    oset = 0;
    uset = 0;
    if (clr) begin
      if (k == 0) mq0.delete(); else mq1.delete();
    end else begin
      popv = rd_en && (sz > 0);
      uset = rd_en && (sz == 0);
      if (popv) mpop(k);
      if (wr_en) begin
        if (sz < 128 || popv) mpush(k, wr_data);
        else begin
          oset = 1;
          if (k == 1) begin
            mpop(k);
            mpush(k, wr_data);
          end
        end
      end
    end
    if (oset) movf[k] = 1; else if (err_clr) movf[k] = 0;
    if (uset) mudf[k] = 1; else if (err_clr) mudf[k] = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq0.delete();
      mq1.delete();
      movf[0] = 0; movf[1] = 0;
      mudf[0] = 0; mudf[1] = 0;
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic cmp_inst(string tag, int k, int rd, int lv, int em, int fu, int ae, int af, int ov, int ud);
    int sz;
    sz = msize(k);
    cmp({tag, ".rd_data"},      rd, mhead(k));
    cmp({tag, ".level"},        lv, sz);
    cmp({tag, ".empty"},        em, int'(sz == 0));
    cmp({tag, ".full"},         fu, int'(sz == 128));
    cmp({tag, ".almost_empty"}, ae, int'(sz <= 8));
    cmp({tag, ".almost_full"},  af, int'(sz >= 96));
    cmp({tag, ".overflow"},     ov, int'(movf[k]));
    cmp({tag, ".underflow"},    ud, int'(mudf[k]));
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp_inst("drop", 0, rd_data0, level0, empty0, full0, ae0, af0, ovf0, udf0);
      cmp_inst("ovw",  1, rd_data1, level1, empty1, full1, ae1, af1, ovf1, udf1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] d);
    wr_en = 1; wr_data = d; tick(); wr_en = 0;
  endtask

  task automatic pop();
    rd_en = 1; tick(); rd_en = 0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1; tick(); err_clr = 0;
  endtask

  task automatic check_reset_vals(string tag);
    cmp({tag, " drop.empty"},    empty0, 1);
    cmp({tag, " drop.full"},     full0, 0);
    cmp({tag, " drop.ae"},       ae0, 1);
    cmp({tag, " drop.af"},       af0, 0);
    cmp({tag, " drop.ovf"},      ovf0, 0);
    cmp({tag, " drop.udf"},      udf0, 0);
    cmp({tag, " drop.rd_data"},  rd_data0, 0);
    cmp({tag, " drop.level"},    level0, 0);
    cmp({tag, " ovw.empty"},     empty1, 1);
    cmp({tag, " ovw.level"},     level1, 0);
    cmp({tag, " ovw.ovf"},       ovf1, 0);
    cmp({tag, " ovw.rd_data"},   rd_data1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int af_first, ae_first;
    logic [7:0] last0, last1;
    logic [7:0] exp1[3];
    exp1[0] = 8'h11; exp1[1] = 8'h22; exp1[2] = 8'h33;

    rst_n = 0; clr = 0; err_clr = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1;
    tick();
    check_en = 1;

    // Test 1: three pushes and three pops.
    push(8'h11); push(8'h22); push(8'h33);
    cmp("t1 level", level0, 3);
    cmp("t1 head", rd_data0, 8'h11);
    for (int i = 0; i < 3; i++) begin
      cmp("t1 pop data", rd_data0, exp1[i]);
      pop();
    end
    cmp("t1 empty", empty0, 1);
    cmp("t1 rd_data zero", rd_data0, 0);

    // Test 2: fill to 128 and drain, checking both thresholds.
    af_first = -1;
    for (int i = 0; i < 128; i++) begin
      push(8'(i));
      if (af0 && af_first < 0) af_first = level0;
    end
    cmp("t2 af first level", af_first, 96);
    cmp("t2 full", full0, 1);
    cmp("t2 level", level0, 128);
    ae_first = -1;
    for (int i = 0; i < 128; i++) begin
      cmp("t2 pop data", rd_data0, i);
      pop();
      if (ae0 && ae_first < 0) ae_first = level0;
    end
    cmp("t2 ae first level", ae_first, 8);

    // Test 3: push while full, in drop mode and in overwrite mode.
    for (int i = 0; i < 128; i++) push(8'(i));
    push(8'hAA);
    cmp("t3 drop ovf", ovf0, 1);
    cmp("t3 drop level", level0, 128);
    cmp("t3 drop head", rd_data0, 8'h00);
    cmp("t3 ovw head", rd_data1, 8'h01);
    cmp("t3 ovw level", level1, 128);
    cmp("t3 ovw ovf", ovf1, 1);
    last0 = 0; last1 = 0;
    for (int i = 0; i < 128; i++) begin
      last0 = rd_data0; last1 = rd_data1;
      pop();
    end
    cmp("t3 drop last", last0, 8'h7F);
    cmp("t3 ovw last", last1, 8'hAA);
    pulse_err_clr();
    cmp("t3 ovf cleared", ovf0, 0);

    // Test 4: push and pop together, first when full, then when empty.
    for (int i = 0; i < 128; i++) push(8'(i + 3));
    wr_en = 1; rd_en = 1; wr_data = 8'h55; tick(); wr_en = 0; rd_en = 0;
    cmp("t4 full level", level0, 128);
    cmp("t4 full no ovf", ovf0, 0);
    cmp("t4 full head", rd_data0, 8'h04);
    repeat (128) pop();
    cmp("t4 drained", empty0, 1);
    wr_en = 1; rd_en = 1; wr_data = 8'h66; tick(); wr_en = 0; rd_en = 0;
    cmp("t4 empty level", level0, 1);
    cmp("t4 empty udf", udf0, 1);
    cmp("t4 empty head", rd_data0, 8'h66);
    pop();
    pulse_err_clr();

    // Test 5: random traffic that wraps the pointers.
    for (int i = 0; i < 300; i++) begin
      wr_en   = ($urandom_range(0, 99) < 55);
      rd_en   = ($urandom_range(0, 99) < 50);
      wr_data = 8'($urandom);
      err_clr = ($urandom_range(0, 19) == 0);
      clr     = ($urandom_range(0, 99) == 0);
      tick();
    end
    wr_en = 0; rd_en = 0; err_clr = 0; clr = 0;
    tick();

    // Test 6: clr with sticky overflow, then reset in the middle of a burst.
    clr = 1; tick(); clr = 0;
    pulse_err_clr();
    for (int i = 0; i < 128; i++) push(8'(i));
    push(8'hEE);
    repeat (123) pop();
    cmp("t6 level5", level0, 5);
    cmp("t6 ovf set", ovf0, 1);
    clr = 1; wr_en = 1; wr_data = 8'h77; tick(); clr = 0; wr_en = 0;
    cmp("t6 clr level", level0, 0);
    cmp("t6 clr keeps ovf", ovf0, 1);
    cmp("t6 clr rd_data", rd_data0, 0);
    pulse_err_clr();
    cmp("t6 err_clr", ovf0, 0);
    wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'h90 + i);
      tick();
    end
    #2;
    rst_n = 0;
    #1;
    check_reset_vals("midrst");
    wr_en = 0;
    tick();
    rst_n = 1;
    tick();
    tick();
    check_reset_vals("after rst");

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
